// File: rtl/prog_loader.sv
// ============================================================================
// Module   : prog_loader
// Purpose  : Assembles a little-endian byte stream into 32-bit words, writes
//            them into instruction memory and releases the core when done.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module prog_loader #(
    parameter int ADDR_W         = 8,
    parameter int WORD_COUNT     = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load_en,
    output logic [31:0]       mem_load_inst,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_run
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RECV  = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    localparam logic [ADDR_W:0] c_WC_LAST = (ADDR_W + 1)'(WORD_COUNT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;

    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W:0]   r_word_count;
    logic [31:0]       r_mem_load_inst;

    logic              r_byte_ready;
    logic              r_mem_load_en;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_run;

    logic              w_byte_ready_nxt;
    logic              w_mem_load_en_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_error_nxt;
    logic              w_cpu_run_nxt;

    logic              w_accept;
    logic              w_start_ok;
    logic              w_last_word;
    logic              w_tmo_hit;

    // byte_ready is registered from the next state, so it is high exactly in RECV.
    assign w_accept    = byte_valid && r_byte_ready;
    assign w_start_ok  = start && ((r_state == c_ST_IDLE) ||
                                   (r_state == c_ST_DONE) ||
                                   (r_state == c_ST_ERR));
    assign w_last_word = (r_word_count == c_WC_LAST);

    // ------------------------------------------------------------------
    // Inter-byte timeout; armed only once the first byte of a load arrives
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo_on
            localparam int c_TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

            logic [c_TMO_W-1:0] r_tmo;
            logic               r_started;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tmo     <= '0;
                    r_started <= 1'b0;
                end else if (w_start_ok) begin
                    r_tmo     <= '0;
                    r_started <= 1'b0;
                end else if (r_state == c_ST_RECV) begin
                    if (w_accept) begin
                        r_tmo     <= '0;
                        r_started <= 1'b1;
                    end else if (r_started) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
            end

            // An acceptance in the expiry cycle wins over the timeout.
            assign w_tmo_hit = (r_state == c_ST_RECV) && r_started && !w_accept &&
                               (r_tmo == c_TMO_LAST);
        end else begin : g_tmo_off
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_RECV;
                end
            end
            c_ST_RECV: begin
                if (w_accept && (r_byte_idx == 2'd3)) begin
                    w_state_next = c_ST_WRITE;
                end else if (w_tmo_hit) begin
                    w_state_next = c_ST_ERR;
                end
            end
            c_ST_WRITE: begin
                w_state_next = w_last_word ? c_ST_DONE : c_ST_RECV;
            end
            c_ST_DONE, c_ST_ERR: begin
                if (start) begin
                    w_state_next = c_ST_RECV;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic, decoded from the next state and then registered
    // ------------------------------------------------------------------
    always_comb begin
        w_byte_ready_nxt  = (w_state_next == c_ST_RECV);
        w_mem_load_en_nxt = (w_state_next == c_ST_WRITE);
        w_busy_nxt        = (w_state_next == c_ST_RECV) || (w_state_next == c_ST_WRITE);
        w_done_nxt        = (w_state_next == c_ST_DONE);
        w_cpu_run_nxt     = (w_state_next == c_ST_DONE);
        w_error_nxt       = (w_state_next == c_ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_ready  <= 1'b0;
            r_mem_load_en <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cpu_run     <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_byte_ready  <= w_byte_ready_nxt;
            r_mem_load_en <= w_mem_load_en_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_cpu_run     <= w_cpu_run_nxt;
            r_error       <= w_error_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: word assembly, address and word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_idx      <= 2'd0;
            r_word          <= 24'd0;
            r_mem_addr      <= '0;
            r_word_count    <= '0;
            r_mem_load_inst <= 32'd0;
        end else if (w_start_ok) begin
            r_byte_idx   <= 2'd0;
            r_word       <= 24'd0;
            r_mem_addr   <= '0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                c_ST_RECV: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0:    r_word[7:0]     <= byte_data;
                            2'd1:    r_word[15:8]    <= byte_data;
                            2'd2:    r_word[23:16]   <= byte_data;
                            default: r_mem_load_inst <= {byte_data, r_word};
                        endcase
                    end
                end
                c_ST_WRITE: begin
                    r_word_count <= r_word_count + 1'b1;
                    r_byte_idx   <= 2'd0;
                    // On the final word the address stays on the last location.
                    if (!w_last_word) begin
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign byte_ready    = r_byte_ready;
    assign mem_addr      = r_mem_addr;
    assign mem_load_en   = r_mem_load_en;
    assign mem_load_inst = r_mem_load_inst;
    assign word_count    = r_word_count;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign cpu_run       = r_cpu_run;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Directed bench for prog_loader with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prog_loader;

    localparam int ADDR_W         = 8;
    localparam int WORD_COUNT     = 256;
    localparam int TIMEOUT_CYCLES = 16;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              start      = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data  = 8'd0;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_load_en;
    logic [31:0]       mem_load_inst;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_run;

    prog_loader #(
        .ADDR_W         (ADDR_W),
        .WORD_COUNT     (WORD_COUNT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .mem_addr      (mem_addr),
        .mem_load_en   (mem_load_en),
        .mem_load_inst (mem_load_inst),
        .word_count    (word_count),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .cpu_run       (cpu_run)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] exp_e;
    logic [31:0]        imem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (mem_load_en) imem[mem_addr] <= mem_load_inst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: pops the scoreboard on every write strobe.
    int cyc         = 0;
    int last_strobe = 0;
    int strobes     = 0;
    bit prev_en     = 1'b0;
    bit prev_valid  = 1'b0;
    bit spacing_on  = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mem_load_en === 1'b1) begin
            strobes++;
            check("strobe_width", 64'(prev_en), 64'(0));
            check("ready_in_write", 64'(byte_ready), 64'(0));
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: addr 0x%0h inst 0x%0h, expected no write",
                         mem_addr, mem_load_inst);
            end else begin
                exp_e = exp_q.pop_front();
                check("write_addr", 64'(mem_addr), 64'(exp_e[ADDR_W+31:32]));
                check("write_inst", 64'(mem_load_inst), 64'(exp_e[31:0]));
            end
            if (spacing_on && prev_valid) check("strobe_spacing", 64'(cyc - last_strobe), 64'(5));
            last_strobe = cyc;
            prev_valid  = spacing_on;
        end else if (!spacing_on) begin
            prev_valid = 1'b0;
        end
        prev_en = (mem_load_en === 1'b1);
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            check("byte_accept_wait", 64'(byte_ready), 64'(1));
            byte_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'(0));
        check({tag, "_load_en"},    64'(mem_load_en), 64'(0));
        check({tag, "_addr"},       64'(mem_addr), 64'(0));
        check({tag, "_inst"},       64'(mem_load_inst), 64'(0));
        check({tag, "_word_count"}, 64'(word_count), 64'(0));
        check({tag, "_busy"},       64'(busy), 64'(0));
        check({tag, "_done"},       64'(done), 64'(0));
        check({tag, "_error"},      64'(error), 64'(0));
        check({tag, "_cpu_run"},    64'(cpu_run), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", 64'(byte_ready), 64'(0));

        // Two words from the basic stream
        expect_write(8'h00, 32'hDEADBEEF);
        expect_write(8'h01, 32'h00000001);
        pulse_start();
        check("start_busy", 64'(busy), 64'(1));
        check("start_ready", 64'(byte_ready), 64'(1));
        send_word(32'hDEADBEEF);
        send_word(32'h00000001);
        repeat (2) @(negedge clk);
        check("two_words_count", 64'(word_count), 64'(2));
        check("two_words_busy", 64'(busy), 64'(1));
        check("two_words_done", 64'(done), 64'(0));

        // start during RECV must not disturb the byte index
        expect_write(8'h02, 32'h44332211);
        @(posedge clk);
        #1;
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (2) @(negedge clk);
        check("ignored_start_count", 64'(word_count), 64'(3));

        // Inter-byte timeout: partial word dropped after 16 idle cycles
        @(posedge clk);
        #1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("tmo_not_yet", 64'(error), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("tmo_error", 64'(error), 64'(1));
        check("tmo_busy", 64'(busy), 64'(0));
        check("tmo_cpu_run", 64'(cpu_run), 64'(0));
        check("tmo_ready", 64'(byte_ready), 64'(0));
        repeat (3) @(negedge clk);
        check("tmo_sticky", 64'(error), 64'(1));
        @(posedge clk);
        #1;
        pulse_start();
        check("tmo_clear_error", 64'(error), 64'(0));
        check("tmo_clear_count", 64'(word_count), 64'(0));
        expect_write(8'h00, 32'hCAFEF00D);
        send_word(32'hCAFEF00D);

        // Reset in the middle of a load
        expect_write(8'h01, 32'h04030201);
        send_word(32'h04030201);
        send_byte(8'h05);
        send_byte(8'h06);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_ready", 64'(byte_ready), 64'(0));
        end
        check("post_rst_busy", 64'(busy), 64'(0));
        byte_valid = 1'b0;

        // Full image, back-to-back stream
        @(posedge clk);
        #1;
        for (int k = 0; k < WORD_COUNT; k++) expect_write(ADDR_W'(k), {24'hDEADBE, 8'(k)});
        spacing_on = 1'b1;
        base       = strobes;
        pulse_start();
        for (int k = 0; k < WORD_COUNT; k++) send_word({24'hDEADBE, 8'(k)});
        repeat (2) @(negedge clk);
        check("full_strobes", 64'(strobes - base), 64'(WORD_COUNT));
        check("full_done", 64'(done), 64'(1));
        check("full_cpu_run", 64'(cpu_run), 64'(1));
        check("full_count", 64'(word_count), 64'(256));
        check("full_ready", 64'(byte_ready), 64'(0));
        check("full_busy", 64'(busy), 64'(0));
        check("full_last_addr", 64'(mem_addr), 64'(8'hFF));
        check("imem_readback", 64'(imem[8'h10]), 64'(32'hDEADBE10));
        repeat (3) @(negedge clk);
        check("done_hold", 64'(done), 64'(1));
        spacing_on = 1'b0;

        // Restart from DONE
        @(posedge clk);
        #1;
        pulse_start();
        check("restart_done", 64'(done), 64'(0));
        check("restart_cpu_run", 64'(cpu_run), 64'(0));
        check("restart_count", 64'(word_count), 64'(0));
        check("restart_busy", 64'(busy), 64'(1));
        expect_write(8'h00, 32'h12345678);
        send_word(32'h12345678);
        repeat (2) @(negedge clk);
        check("restart_word_count", 64'(word_count), 64'(1));

        repeat (3) @(negedge clk);
        check("pending_writes", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
